// File: rtl/pcie_hip_st_bridge.sv
// Avalon-ST bridge between the PCIe hard IP and RIFFA: absorbs HIP ready latency on RX/TX
// and serialises MSI triggers into the app_msi_req/ack handshake.
module pcie_hip_st_bridge #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_RX_LATENCY = 2,
  parameter int C_TX_LATENCY = 2,
  parameter int C_RX_DEPTH   = 8,
  localparam int C_EMPTY_W   = (C_DATA_WIDTH > 128) ? $clog2(C_DATA_WIDTH / 64) : 1
) (
  input  logic                    pld_clk,
  input  logic                    npor,
  input  logic                    hip_rx_st_sop,
  input  logic                    hip_rx_st_eop,
  input  logic                    hip_rx_st_valid,
  input  logic [C_DATA_WIDTH-1:0] hip_rx_st_data,
  input  logic [C_EMPTY_W-1:0]    hip_rx_st_empty,
  output logic                    hip_rx_st_ready,
  output logic                    app_rx_sop,
  output logic                    app_rx_eop,
  output logic                    app_rx_valid,
  output logic [C_DATA_WIDTH-1:0] app_rx_data,
  output logic [C_EMPTY_W-1:0]    app_rx_empty,
  input  logic                    app_rx_ready,
  input  logic                    app_tx_sop,
  input  logic                    app_tx_eop,
  input  logic                    app_tx_valid,
  input  logic [C_DATA_WIDTH-1:0] app_tx_data,
  input  logic [C_EMPTY_W-1:0]    app_tx_empty,
  output logic                    app_tx_ready,
  output logic                    hip_tx_st_sop,
  output logic                    hip_tx_st_eop,
  output logic                    hip_tx_st_valid,
  output logic [C_DATA_WIDTH-1:0] hip_tx_st_data,
  output logic [C_EMPTY_W-1:0]    hip_tx_st_empty,
  input  logic                    hip_tx_st_ready,
  input  logic                    msi_trig,
  input  logic [4:0]              msi_num,
  output logic                    hip_app_msi_req,
  output logic [4:0]              hip_app_msi_num,
  input  logic                    hip_app_msi_ack,
  output logic                    rx_overflow,
  output logic                    tx_proto_err,
  output logic                    msi_drop
);

  localparam int PW = $clog2(C_RX_DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int EW = C_DATA_WIDTH + C_EMPTY_W + 2;

  // ---------------- RX buffer ----------------
  logic [EW-1:0] rx_mem [C_RX_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] rx_count, rx_count_next, rx_free_next;
  logic          rx_empty, rx_full, rx_push, rx_pop;
  logic          rx_ready_reg, rx_overflow_reg;
  logic [EW-1:0] rx_head;

  assign rx_count      = wr_ptr_reg - rd_ptr_reg;
  assign rx_empty      = (rx_count == '0);
  assign rx_full       = (rx_count == PW'(C_RX_DEPTH));
  assign rx_pop        = !rx_empty && app_rx_ready;
  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign rx_push       = hip_rx_st_valid && (!rx_full || rx_pop);
  assign rx_count_next = rx_count + PW'(rx_push) - PW'(rx_pop);
  assign rx_free_next  = PW'(C_RX_DEPTH) - rx_count_next;

  always_ff @(posedge pld_clk) begin
    if (rx_push)
      rx_mem[wr_ptr_reg[AW-1:0]] <= {hip_rx_st_sop, hip_rx_st_eop, hip_rx_st_empty, hip_rx_st_data};
  end

  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rx_ready_reg    <= 1'b0;
      rx_overflow_reg <= 1'b0;
    end else begin
      if (rx_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rx_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      rx_ready_reg <= (rx_free_next >= PW'(C_RX_LATENCY + 2));
      if (hip_rx_st_valid && rx_full && !rx_pop) rx_overflow_reg <= 1'b1;
    end
  end

  assign rx_head         = rx_mem[rd_ptr_reg[AW-1:0]];
  assign hip_rx_st_ready = rx_ready_reg;
  assign rx_overflow     = rx_overflow_reg;
  assign app_rx_valid    = !rx_empty;
  assign {app_rx_sop, app_rx_eop, app_rx_empty, app_rx_data} = rx_empty ? '0 : rx_head;

  // ---------------- TX path ----------------
  logic [C_TX_LATENCY-1:0] rdy_sr_reg;
  logic                    in_pkt_reg, tx_proto_err_reg;

  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      rdy_sr_reg       <= '0;
      in_pkt_reg       <= 1'b0;
      tx_proto_err_reg <= 1'b0;
    end else begin
      rdy_sr_reg <= C_TX_LATENCY'({rdy_sr_reg, hip_tx_st_ready});
      if (hip_tx_st_valid) begin
        // Legal only when sop opens a packet or a non-sop beat continues one.
        if (app_tx_sop == in_pkt_reg) tx_proto_err_reg <= 1'b1;
        if (app_tx_eop)      in_pkt_reg <= 1'b0;
        else if (app_tx_sop) in_pkt_reg <= 1'b1;
      end
    end
  end

  assign app_tx_ready    = rdy_sr_reg[C_TX_LATENCY-1];
  assign hip_tx_st_valid = app_tx_valid && app_tx_ready;
  assign hip_tx_st_sop   = app_tx_sop;
  assign hip_tx_st_eop   = app_tx_eop;
  assign hip_tx_st_data  = app_tx_data;
  assign hip_tx_st_empty = app_tx_empty;
  assign tx_proto_err    = tx_proto_err_reg;

  // ---------------- MSI handshake ----------------
  typedef enum logic [1:0] {MSI_IDLE, MSI_REQ, MSI_GAP} msi_state_t;
  msi_state_t msi_state_reg;
  logic       msi_req_reg, pending_v_reg, msi_drop_reg;
  logic [4:0] msi_num_reg, pending_num_reg;
  logic       msi_consume, msi_direct, msi_busy_trig, msi_store;

  assign msi_consume   = (msi_state_reg == MSI_GAP) && pending_v_reg;
  // A trigger in GAP with nothing pending is queued and consumed at once, so it goes straight to REQ.
  assign msi_direct    = (msi_state_reg == MSI_GAP) && !pending_v_reg && msi_trig;
  assign msi_busy_trig = msi_trig && (msi_state_reg != MSI_IDLE) && !msi_direct;
  assign msi_store     = msi_busy_trig && (!pending_v_reg || msi_consume);

  always_ff @(posedge pld_clk or negedge npor) begin
    if (!npor) begin
      msi_state_reg   <= MSI_IDLE;
      msi_req_reg     <= 1'b0;
      msi_num_reg     <= '0;
      pending_v_reg   <= 1'b0;
      pending_num_reg <= '0;
      msi_drop_reg    <= 1'b0;
    end else begin
      case (msi_state_reg)
        MSI_IDLE: if (msi_trig) begin
          msi_state_reg <= MSI_REQ;
          msi_req_reg   <= 1'b1;
          msi_num_reg   <= msi_num;
        end
        MSI_REQ: if (hip_app_msi_ack) begin
          msi_state_reg <= MSI_GAP;
          msi_req_reg   <= 1'b0;
        end
        MSI_GAP: if (pending_v_reg) begin
          msi_state_reg <= MSI_REQ;
          msi_req_reg   <= 1'b1;
          msi_num_reg   <= pending_num_reg;
        end else if (msi_trig) begin
          msi_state_reg <= MSI_REQ;
          msi_req_reg   <= 1'b1;
          msi_num_reg   <= msi_num;
        end else begin
          msi_state_reg <= MSI_IDLE;
        end
        default: msi_state_reg <= MSI_IDLE;
      endcase
      if (msi_store) begin
        pending_num_reg <= msi_num;
        pending_v_reg   <= 1'b1;
      end else if (msi_consume) begin
        pending_v_reg   <= 1'b0;
      end
      if (msi_busy_trig && !msi_store) msi_drop_reg <= 1'b1;
    end
  end

  assign hip_app_msi_req = msi_req_reg;
  assign hip_app_msi_num = msi_num_reg;
  assign msi_drop        = msi_drop_reg;

endmodule

// File: tb/tb_pcie_hip_st_bridge.sv
// Scoreboard bench for pcie_hip_st_bridge: RX ordering/latency/backpressure, TX ready delay and
// protocol flag, MSI serialisation and asynchronous reset.
module tb_pcie_hip_st_bridge;
  localparam int DW    = 128;
  localparam int RXL   = 2;
  localparam int TXL   = 2;
  localparam int DEPTH = 8;
  localparam int EMW   = (DW > 128) ? $clog2(DW / 64) : 1;
  localparam int BW    = DW + EMW + 2;

  logic clk = 1'b0;
  logic npor = 1'b0;
  always #5 clk = ~clk;

  logic          hip_rx_st_sop, hip_rx_st_eop, hip_rx_st_valid, hip_rx_st_ready;
  logic [DW-1:0] hip_rx_st_data;
  logic [EMW-1:0] hip_rx_st_empty;
  logic          app_rx_sop, app_rx_eop, app_rx_valid, app_rx_ready;
  logic [DW-1:0] app_rx_data;
  logic [EMW-1:0] app_rx_empty;
  logic          app_tx_sop, app_tx_eop, app_tx_valid, app_tx_ready;
  logic [DW-1:0] app_tx_data;
  logic [EMW-1:0] app_tx_empty;
  logic          hip_tx_st_sop, hip_tx_st_eop, hip_tx_st_valid, hip_tx_st_ready;
  logic [DW-1:0] hip_tx_st_data;
  logic [EMW-1:0] hip_tx_st_empty;
  logic          msi_trig, hip_app_msi_req, hip_app_msi_ack;
  logic [4:0]    msi_num, hip_app_msi_num;
  logic          rx_overflow, tx_proto_err, msi_drop;

  pcie_hip_st_bridge #(
    .C_DATA_WIDTH(DW), .C_RX_LATENCY(RXL), .C_TX_LATENCY(TXL), .C_RX_DEPTH(DEPTH)
  ) dut (
    .pld_clk(clk), .npor(npor),
    .hip_rx_st_sop(hip_rx_st_sop), .hip_rx_st_eop(hip_rx_st_eop), .hip_rx_st_valid(hip_rx_st_valid),
    .hip_rx_st_data(hip_rx_st_data), .hip_rx_st_empty(hip_rx_st_empty), .hip_rx_st_ready(hip_rx_st_ready),
    .app_rx_sop(app_rx_sop), .app_rx_eop(app_rx_eop), .app_rx_valid(app_rx_valid),
    .app_rx_data(app_rx_data), .app_rx_empty(app_rx_empty), .app_rx_ready(app_rx_ready),
    .app_tx_sop(app_tx_sop), .app_tx_eop(app_tx_eop), .app_tx_valid(app_tx_valid),
    .app_tx_data(app_tx_data), .app_tx_empty(app_tx_empty), .app_tx_ready(app_tx_ready),
    .hip_tx_st_sop(hip_tx_st_sop), .hip_tx_st_eop(hip_tx_st_eop), .hip_tx_st_valid(hip_tx_st_valid),
    .hip_tx_st_data(hip_tx_st_data), .hip_tx_st_empty(hip_tx_st_empty), .hip_tx_st_ready(hip_tx_st_ready),
    .msi_trig(msi_trig), .msi_num(msi_num),
    .hip_app_msi_req(hip_app_msi_req), .hip_app_msi_num(hip_app_msi_num), .hip_app_msi_ack(hip_app_msi_ack),
    .rx_overflow(rx_overflow), .tx_proto_err(tx_proto_err), .msi_drop(msi_drop)
  );

  logic [DW+EMW+14:0] out_vec;
  assign out_vec = {hip_rx_st_ready, app_rx_valid, app_rx_sop, app_rx_eop, app_rx_empty, app_rx_data,
                    app_tx_ready, hip_tx_st_valid, hip_app_msi_req, hip_app_msi_num,
                    rx_overflow, tx_proto_err, msi_drop};

  int checks = 0;
  int errors = 0;
  int rx_got = 0;
  int bidx   = 0;
  logic [BW-1:0] rx_q[$];
  logic [BW-1:0] tx_q[$];
  logic [4:0]    msi_q[$];

  function automatic logic [BW-1:0] mk_beat(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'h5A00_0000;
    return {(i % 4 == 0), (i % 4 == 3), EMW'(i), {(DW / 32){w}}};
  endfunction

  task automatic drive_rx(input logic v, input logic [BW-1:0] b);
    {hip_rx_st_sop, hip_rx_st_eop, hip_rx_st_empty, hip_rx_st_data} = b;
    hip_rx_st_valid = v;
  endtask

  // RX scoreboard: every accepted app_rx beat must match the oldest outstanding HIP beat.
  always @(negedge clk) begin
    #2;
    if (npor && app_rx_valid && app_rx_ready) begin
      logic [BW-1:0] got, exp;
      got = {app_rx_sop, app_rx_eop, app_rx_empty, app_rx_data};
      rx_got++;
      checks++;
      if (rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got=%h required=none", got);
      end else begin
        exp = rx_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL rx_beat got=%h required=%h", got, exp);
        end
      end
    end
  end

  task automatic test_reset;
    npor = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", out_vec);
    end
    @(negedge clk) npor = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hip_rx_st_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready got=%b required=1", hip_rx_st_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_rx_stream;
    app_rx_ready = 1'b1;
    rx_got = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k < 16) begin
        drive_rx(1'b1, mk_beat(bidx));
        rx_q.push_back(mk_beat(bidx));
        bidx++;
      end else begin
        drive_rx(1'b0, '0);
      end
      #1;
      checks++;
      if (app_rx_valid !== (k >= 1 && k <= 16)) begin
        errors++;
        $display("FAIL rx_latency cycle=%0d got=%b required=%b", k, app_rx_valid, (k >= 1 && k <= 16));
      end
    end
    @(negedge clk);
    #3;
    checks++;
    if (rx_got != 16 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_stream delivered=%0d overflow=%b required=16/0", rx_got, rx_overflow);
    end
    $display("test_rx_stream delivered=%0d", rx_got);
  endtask

  task automatic test_rx_backpressure;
    logic h1, h2, cur, saw_low;
    int sent, late, peak;
    h1 = 1'b1; h2 = 1'b1; saw_low = 1'b0;
    sent = 0; late = 0; peak = 0; rx_got = 0;
    for (int k = 0; k < 200 && (sent < 24 || rx_q.size() != 0); k++) begin
      @(negedge clk);
      cur = hip_rx_st_ready;
      app_rx_ready = (k >= 20);
      if (h2 && sent < 24) begin
        drive_rx(1'b1, mk_beat(bidx));
        rx_q.push_back(mk_beat(bidx));
        bidx++;
        sent++;
        if (!cur) late++;
      end else begin
        drive_rx(1'b0, '0);
      end
      if (!cur) saw_low = 1'b1;
      if (sent - rx_got > peak) peak = sent - rx_got;
      h2 = h1;
      h1 = cur;
    end
    drive_rx(1'b0, '0);
    @(negedge clk);
    #3;
    checks++;
    if (rx_q.size() != 0 || rx_got != 24) begin
      errors++;
      $display("FAIL rx_bp_delivered got=%0d pending=%0d required=24/0", rx_got, rx_q.size());
    end
    checks++;
    if (!saw_low || late != 2) begin
      errors++;
      $display("FAIL rx_bp_ready saw_low=%b late=%0d required=1/2", saw_low, late);
    end
    checks++;
    if (rx_overflow !== 1'b0 || peak > DEPTH) begin
      errors++;
      $display("FAIL rx_bp_overflow got=%b peak=%0d required=0/<=%0d", rx_overflow, peak, DEPTH);
    end
    $display("test_rx_backpressure sent=%0d late=%0d peak=%0d", sent, late, peak);
  endtask

  task automatic test_rx_full_push_pop;
    rx_got = 0;
    app_rx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive_rx(1'b1, mk_beat(bidx));
      rx_q.push_back(mk_beat(bidx));
      bidx++;
      app_rx_ready = (k == 8);
    end
    @(negedge clk);
    drive_rx(1'b0, '0);
    app_rx_ready = 1'b1;
    for (int k = 0; k < 40 && rx_q.size() != 0; k++) @(negedge clk);
    #3;
    checks++;
    if (rx_got != 9 || rx_q.size() != 0 || rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_full_push_pop delivered=%0d overflow=%b required=9/0", rx_got, rx_overflow);
    end
    $display("test_rx_full_push_pop delivered=%0d", rx_got);
  endtask

  task automatic test_rx_overflow;
    rx_got = 0;
    app_rx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive_rx(1'b1, mk_beat(bidx));
      if (k < 8) rx_q.push_back(mk_beat(bidx));
      bidx++;
    end
    @(negedge clk);
    drive_rx(1'b0, '0);
    #1;
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL rx_overflow_flag got=%b required=1", rx_overflow);
    end
    app_rx_ready = 1'b1;
    for (int k = 0; k < 40 && rx_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    #3;
    checks++;
    if (rx_got != 8 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rx_overflow_drain delivered=%0d required=8", rx_got);
    end
    $display("test_rx_overflow delivered=%0d", rx_got);
  endtask

  task automatic test_tx_ready_latency;
    int pat[9];
    int tx_idx, pushed_idx, fwd;
    logic exp_v;
    logic [BW-1:0] b, exp;
    pat = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    tx_idx = 0; pushed_idx = -1; fwd = 0;
    hip_tx_st_ready = 1'b0;
    app_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      hip_tx_st_ready = (pat[k] != 0);
      b = mk_beat(100 + tx_idx);
      b[BW-1] = 1'b1;
      b[BW-2] = 1'b1;
      {app_tx_sop, app_tx_eop, app_tx_empty, app_tx_data} = b;
      app_tx_valid = 1'b1;
      if (pushed_idx != tx_idx) begin
        tx_q.push_back(b);
        pushed_idx = tx_idx;
      end
      #1;
      exp_v = (k >= 2) ? (pat[k-2] != 0) : 1'b0;
      checks++;
      if (hip_tx_st_valid !== exp_v) begin
        errors++;
        $display("FAIL tx_valid cycle=%0d got=%b required=%b", k, hip_tx_st_valid, exp_v);
      end
      if (hip_tx_st_valid === 1'b1 && tx_q.size() != 0) begin
        exp = tx_q.pop_front();
        fwd++;
        tx_idx++;
        checks++;
        if ({hip_tx_st_sop, hip_tx_st_eop, hip_tx_st_empty, hip_tx_st_data} !== exp) begin
          errors++;
          $display("FAIL tx_data got=%h required=%h", hip_tx_st_data, exp[DW-1:0]);
        end
      end
    end
    @(negedge clk);
    app_tx_valid = 1'b0;
    tx_q.delete();
    #1;
    checks++;
    if (fwd != 3 || tx_proto_err !== 1'b0) begin
      errors++;
      $display("FAIL tx_latency_summary forwarded=%0d proto=%b required=3/0", fwd, tx_proto_err);
    end
    $display("test_tx_ready_latency forwarded=%0d", fwd);
  endtask

  task automatic test_tx_proto;
    logic [DW-1:0] d;
    int fwd;
    fwd = 0;
    hip_tx_st_ready = 1'b1;
    app_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = DW'(32'hC0DE_0000 + k);
      app_tx_sop = (k < 2);
      app_tx_eop = (k == 2);
      app_tx_empty = '0;
      app_tx_data = d;
      app_tx_valid = 1'b1;
      #1;
      if (hip_tx_st_valid === 1'b1) fwd++;
      checks++;
      if (hip_tx_st_valid !== 1'b1 || hip_tx_st_data !== d) begin
        errors++;
        $display("FAIL tx_proto_fwd beat=%0d valid=%b data=%h required=1/%h", k, hip_tx_st_valid, hip_tx_st_data, d);
      end
      checks++;
      if (tx_proto_err !== (k == 2)) begin
        errors++;
        $display("FAIL tx_proto_flag beat=%0d got=%b required=%b", k, tx_proto_err, (k == 2));
      end
    end
    @(negedge clk);
    app_tx_valid = 1'b0;
    app_tx_sop = 1'b0;
    app_tx_eop = 1'b0;
    app_tx_data = '0;
    #1;
    checks++;
    if (tx_proto_err !== 1'b1 || fwd != 3) begin
      errors++;
      $display("FAIL tx_proto_sticky got=%b forwarded=%0d required=1/3", tx_proto_err, fwd);
    end
    $display("test_tx_proto forwarded=%0d", fwd);
  endtask

  task automatic test_msi;
    int tt[13], tv[13], ta[13];
    int rises;
    logic prev_req;
    logic [4:0] cur;
    tt = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tv = '{3, 7, 9, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0};
    ta = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    msi_q.push_back(5'd3);
    msi_q.push_back(5'd7);
    msi_q.push_back(5'd11);
    rises = 0; prev_req = 1'b0; cur = '0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      msi_trig = (tt[k] != 0);
      msi_num = 5'(tv[k]);
      hip_app_msi_ack = (ta[k] != 0);
      #1;
      if (hip_app_msi_req === 1'b1 && !prev_req) begin
        rises++;
        checks++;
        if (msi_q.size() == 0) begin
          errors++;
          $display("FAIL msi_unexpected got=%0d", hip_app_msi_num);
        end else begin
          cur = msi_q.pop_front();
          if (hip_app_msi_num !== cur) begin
            errors++;
            $display("FAIL msi_num got=%0d required=%0d", hip_app_msi_num, cur);
          end
        end
      end else if (hip_app_msi_req === 1'b1) begin
        checks++;
        if (hip_app_msi_num !== cur) begin
          errors++;
          $display("FAIL msi_num_stable got=%0d required=%0d", hip_app_msi_num, cur);
        end
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (msi_drop !== (k == 3)) begin
          errors++;
          $display("FAIL msi_drop cycle=%0d got=%b required=%b", k, msi_drop, (k == 3));
        end
      end
      prev_req = hip_app_msi_req;
    end
    @(negedge clk);
    msi_trig = 1'b0;
    hip_app_msi_ack = 1'b0;
    #1;
    checks++;
    if (rises != 3 || msi_q.size() != 0 || hip_app_msi_req !== 1'b0) begin
      errors++;
      $display("FAIL msi_sequence requests=%0d left=%0d req=%b required=3/0/0", rises, msi_q.size(), hip_app_msi_req);
    end
    $display("test_msi requests=%0d", rises);
  endtask

  task automatic test_reset_mid;
    int rises;
    logic prev_req;
    @(negedge clk);
    msi_trig = 1'b1; msi_num = 5'd4;
    @(negedge clk);
    msi_num = 5'd6;
    @(negedge clk);
    msi_trig = 1'b0;
    #1;
    checks++;
    if (hip_app_msi_req !== 1'b1 || hip_app_msi_num !== 5'd4) begin
      errors++;
      $display("FAIL rst_mid_pre req=%b num=%0d required=1/4", hip_app_msi_req, hip_app_msi_num);
    end
    #1 npor = 1'b0;
    #1;
    checks++;
    if (out_vec !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%h required=0", out_vec);
    end
    @(negedge clk) npor = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (hip_app_msi_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle req=%b required=0", hip_app_msi_req);
    end
    rises = 0;
    prev_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      hip_app_msi_ack = hip_app_msi_req;
      msi_trig = (k == 0);
      msi_num = 5'd12;
      #1;
      if (hip_app_msi_req === 1'b1 && !prev_req) begin
        rises++;
        checks++;
        if (hip_app_msi_num !== 5'd12) begin
          errors++;
          $display("FAIL rst_mid_new_msi got=%0d required=12", hip_app_msi_num);
        end
      end
      prev_req = hip_app_msi_req;
    end
    msi_trig = 1'b0;
    hip_app_msi_ack = 1'b0;
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL rst_mid_requests got=%0d required=1", rises);
    end
    $display("test_reset_mid requests=%0d", rises);
  endtask

  initial begin
    drive_rx(1'b0, '0);
    app_rx_ready = 1'b0;
    app_tx_sop = 1'b0; app_tx_eop = 1'b0; app_tx_valid = 1'b0;
    app_tx_data = '0; app_tx_empty = '0;
    hip_tx_st_ready = 1'b0;
    msi_trig = 1'b0; msi_num = '0; hip_app_msi_ack = 1'b0;
    test_reset;
    test_rx_stream;
    test_rx_backpressure;
    test_rx_full_push_pop;
    test_rx_overflow;
    test_tx_ready_latency;
    test_tx_proto;
    test_msi;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
